// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-flop sync, shared prescaled sample tick, N-sample agreement filter.
// Optional per-channel long-press pulse when DEBOUNCE_HOLD_EN is defined.
module debounce_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned TICK_DIV   = 300,
  parameter int unsigned TICK_W     = 9,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned HOLD_TICKS = 1000,
  parameter int unsigned HOLD_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] hold,
  output logic                tick
);

  localparam logic [CHANNELS-1:0] POL       = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(STABLE_CNT - 1);

  // Elaboration-time parameter sanity checks
  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be at least 1");
  end
  if (TICK_DIV < 2 || (64'(1) << TICK_W) < 64'(TICK_DIV)) begin : g_bad_tick
    $error("TICK_DIV must be >= 2 and fit in TICK_W bits");
  end
  if (STABLE_CNT < 1 || (64'(1) << CNT_W) < 64'(STABLE_CNT)) begin : g_bad_cnt
    $error("STABLE_CNT must be >= 1 and fit in CNT_W bits");
  end
  if (HOLD_TICKS < 1 || (64'(1) << HOLD_W) <= 64'(HOLD_TICKS)) begin : g_bad_hold
    $error("HOLD_TICKS must be >= 1 and fit in HOLD_W bits");
  end

  logic [CHANNELS-1:0]             sync1_q, sync2_q;
  logic [TICK_W-1:0]               presc_q, presc_d;
  logic                            tick_q, tick_d;
  logic                            tick_c;
  logic [CHANNELS-1:0]             samp_c;
  logic [CHANNELS-1:0]             state_q, state_d;
  logic [CHANNELS-1:0]             press_q, press_d;
  logic [CHANNELS-1:0]             release_q, release_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  // Synchronisers reset to the inactive raw level so the normalised sample starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= POL;
      sync2_q <= POL;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign samp_c = sync2_q ^ POL;
  assign tick_c = enable && (presc_q == TICK_LAST);

  // Prescaler and per-channel agreement counters; state/pulses land one cycle after tick_c,
  // aligned with the registered tick output
  always_comb begin
    presc_d   = presc_q;
    tick_d    = tick_c;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    if (enable) begin
      presc_d = tick_c ? '0 : presc_q + TICK_W'(1);
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (tick_c) begin
        if (samp_c[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]     = '0;
          state_d[i]   = ~state_q[i];
          press_d[i]   = ~state_q[i];
          release_d[i] = state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      state_q   <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state     = state_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign tick      = tick_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(HOLD_TICKS - 1);

  logic [CHANNELS-1:0][HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [CHANNELS-1:0]             hold_q, hold_d;

  // Counts ticks spent ON after the press tick; saturates so each press yields one pulse
  always_comb begin
    hcnt_d = hcnt_q;
    hold_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (tick_c) begin
        if (state_q[i] && state_d[i]) begin
          if (hcnt_q[i] != HOLD_LAST) begin
            hcnt_d[i] = hcnt_q[i] + HOLD_W'(1);
            hold_d[i] = (hcnt_q[i] == HOLD_PRE);
          end
        end else begin
          hcnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      hold_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;
`else
  assign hold = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random traffic against
// a run-length reference model of the debounce rules.
module tb_debounce_multi;

  localparam int unsigned CH    = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned STAB  = 3;
  localparam int unsigned HOLDT = 5;
  localparam int unsigned AL    = 0;

  logic          clk = 1'b0;
  logic          rst_r = 1'b1;
  logic          en_r = 1'b1;
  logic [CH-1:0] in_r = '0;
  logic [CH-1:0] state_w, press_w, rel_w, hold_w;
  logic          tick_w;

  debounce_multi #(
    .CHANNELS(CH), .TICK_DIV(DIV), .TICK_W(2), .STABLE_CNT(STAB), .CNT_W(2),
    .ACTIVE_LOW(AL), .HOLD_TICKS(HOLDT), .HOLD_W(3)
  ) dut (
    .clk(clk), .reset(rst_r), .enable(en_r), .in(in_r),
    .state(state_w), .press(press_w), .release_o(rel_w), .hold(hold_w), .tick(tick_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sample pipeline, tick phase, run length of disagreeing samples
  int          presc;
  bit [CH-1:0] m_s1, m_s2, m_state, m_press, m_rel, m_hold;
  bit          m_tick;
  int          run[CH];
  int          holdc[CH];

  // Observed pulse tallies for scenario-level checks
  int n_press[CH];
  int n_rel[CH];
  int n_hold[CH];
  int n_tick;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    presc = 0; m_s1 = '0; m_s2 = '0; m_state = '0;
    m_press = '0; m_rel = '0; m_hold = '0; m_tick = 1'b0;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      holdc[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit fire;
    bit old;
    if (rst_r) begin
      model_reset();
      return;
    end
    fire = en_r && (presc == DIV - 1);
    if (en_r) presc = fire ? 0 : presc + 1;
    m_tick = fire; m_press = '0; m_rel = '0; m_hold = '0;
    for (int c = 0; c < CH; c++) begin
      if (fire) begin
        old = m_state[c];
        if (m_s2[c] == old) run[c] = 0;
        else if (run[c] + 1 == STAB) begin
          m_state[c] = ~old;
          run[c] = 0;
          if (old) m_rel[c] = 1'b1; else m_press[c] = 1'b1;
        end else run[c]++;
`ifdef DEBOUNCE_HOLD_EN
        if (old && m_state[c]) begin
          if (holdc[c] < HOLDT) begin
            holdc[c]++;
            if (holdc[c] == HOLDT) m_hold[c] = 1'b1;
          end
        end else holdc[c] = 0;
`endif
      end
    end
    m_s2 = m_s1;
    m_s1 = in_r ^ CH'(AL != 0 ? 4'hF : 4'h0);
  endtask

  task automatic compare_all();
    check("state", state_w, m_state);
    check("press", press_w, m_press);
    check("release", rel_w, m_rel);
    check("hold", hold_w, m_hold);
    check("tick", {3'b000, tick_w}, {3'b000, m_tick});
    check("press_and_release", press_w & rel_w, '0);
    for (int c = 0; c < CH; c++) begin
      n_press[c] += int'(press_w[c]);
      n_rel[c]   += int'(rel_w[c]);
      n_hold[c]  += int'(hold_w[c]);
    end
    n_tick += int'(tick_w);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_hold[c] = 0;
    end
    n_tick = 0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    model_reset();
    clear_counts();

    // Reset state
    step(3);
    @(negedge clk);
    rst_r = 1'b0;

    // 1: single channel step on in[0]
    in_r = 4'b0001;
    step(24);
    check("t1_state", state_w, 4'b0001);
    check_int("t1_press0", n_press[0], 1);
    check_int("t1_press_other", n_press[1] + n_press[2] + n_press[3], 0);

    // 2: in[1] toggling every 5 clks is rejected
    clear_counts();
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) in_r[1] = ~in_r[1];
      step(1);
    end
    in_r[1] = 1'b0;
    step(16);
    check_int("t2_press1", n_press[1], 0);
    check_int("t2_rel1", n_rel[1], 0);
    check("t2_state1", {3'b000, state_w[1]}, 4'b0000);

    // 3: release of in[0]
    clear_counts();
    in_r[0] = 1'b0;
    step(24);
    check_int("t3_rel0", n_rel[0], 1);
    check_int("t3_press0", n_press[0], 0);

    // 4: enable dropped mid-count freezes the filter
    clear_counts();
    in_r[0] = 1'b1;
    step(7);
    en_r = 1'b0;
    clear_counts();
    step(20);
    check_int("t4_tick_frozen", n_tick, 0);
    check_int("t4_press_frozen", n_press[0], 0);
    en_r = 1'b1;
    step(24);
    check_int("t4_press_resume", n_press[0], 1);

    // 5: async reset with all channels on
    in_r = 4'b1111;
    step(30);
    check("t5_all_on", state_w, 4'b1111);
    clear_counts();
    rst_r = 1'b1;
    #1;
    model_reset();
    check("t5_async_state", state_w, 4'b0000);
    check("t5_async_release", rel_w, 4'b0000);
    step(2);
    @(negedge clk);
    rst_r = 1'b0;
    step(30);
    check("t5_redebounce", state_w, 4'b1111);
    check_int("t5_no_release", n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3], 0);

    // 6: long hold on in[2]
    in_r = 4'b0000;
    step(24);
    clear_counts();
    in_r[2] = 1'b1;
    step(80);
`ifdef DEBOUNCE_HOLD_EN
    check_int("t6_hold2", n_hold[2], 1);
`else
    check_int("t6_hold2", n_hold[2], 0);
`endif

    // Random traffic, with occasional enable drops and resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) in_r = CH'($urandom());
      en_r = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_r = 1'b1;
        #1;
        model_reset();
        check("rand_async_reset", state_w | press_w | rel_w | hold_w, 4'b0000);
        step(1);
        @(negedge clk);
        rst_r = 1'b0;
      end
      step($urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
